// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: display back end for the double-dabble converter.
// Captures three BCD digits on a load strobe and time-multiplexes them onto a
// shared 7-segment bus with one-hot digit enables. A value that arrives while
// the display is scanning is held and committed only at a frame boundary
// (the D3->D1 wrap), so one frame never mixes old and new digits.
// Optional feature macro: LEAD_ZERO_BLANK_EN (blank leading zeros in the
// hundreds and tens slots). Without it all three digits are always shown.
module bcd_seg_scan #(
  parameter int REFRESH_DIV    = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] digit3,
  input  logic [3:0] digit2,
  input  logic [3:0] digit1,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       ready,
  output logic       frame
);

  // Dwell counter counts 0..REFRESH_DIV-1; keep it at least one bit wide so
  // REFRESH_DIV=1 still elaborates.
  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    D1   = 2'd1,
    D2   = 2'd2,
    D3   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [DW-1:0]   r_dwell;
  logic [DW-1:0]   w_nextDwell;
  logic            w_slotDone;
  logic            w_wrap;

  logic [3:0]      r_shadowDigit3;
  logic [3:0]      r_shadowDigit2;
  logic [3:0]      r_shadowDigit1;
  logic [3:0]      r_pendDigit3;
  logic [3:0]      r_pendDigit2;
  logic [3:0]      r_pendDigit1;
  logic            r_pending;
  logic            r_frame;

  logic [3:0]      w_slotDigit;
  logic            w_slotBlank;
  logic            w_blankHundreds;
  logic            w_blankTens;
  logic [6:0]      w_segRaw;
  logic [2:0]      w_anRaw;

  // BCD to {g,f,e,d,c,b,a}; codes 10..15 are not BCD and show a dash.
  function automatic logic [6:0] decodeBcd(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'd0:    pattern = 7'h3F;
      4'd1:    pattern = 7'h06;
      4'd2:    pattern = 7'h5B;
      4'd3:    pattern = 7'h4F;
      4'd4:    pattern = 7'h66;
      4'd5:    pattern = 7'h6D;
      4'd6:    pattern = 7'h7D;
      4'd7:    pattern = 7'h07;
      4'd8:    pattern = 7'h7F;
      4'd9:    pattern = 7'h6F;
      default: pattern = 7'h40;
    endcase
    return pattern;
  endfunction

  // Next-state logic: a load wakes the scanner from IDLE, then each digit slot
  // lasts REFRESH_DIV cycles and the D3->D1 transition marks the frame wrap.
  always_comb begin
    w_nextState = r_state;
    w_nextDwell = r_dwell;
    w_slotDone  = (r_dwell == DWELL_LAST);
    w_wrap      = 1'b0;
    case (r_state)
      IDLE: begin
        w_nextDwell = '0;
        if (load) begin
          w_nextState = D1;
        end
      end
      D1: begin
        if (w_slotDone) begin
          w_nextState = D2;
          w_nextDwell = '0;
        end else begin
          w_nextDwell = r_dwell + DW'(1);
        end
      end
      D2: begin
        if (w_slotDone) begin
          w_nextState = D3;
          w_nextDwell = '0;
        end else begin
          w_nextDwell = r_dwell + DW'(1);
        end
      end
      D3: begin
        if (w_slotDone) begin
          w_nextState = D1;
          w_nextDwell = '0;
          w_wrap      = 1'b1;
        end else begin
          w_nextDwell = r_dwell + DW'(1);
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextDwell = '0;
      end
    endcase
  end

  // State and dwell registers; clear drops straight back to IDLE.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state <= IDLE;
      r_dwell <= '0;
    end else begin
      r_state <= w_nextState;
      r_dwell <= w_nextDwell;
    end
  end

  // Digit capture: from IDLE the value goes straight to the shadow; while
  // scanning it is parked in the pend registers and promoted at the wrap. A
  // load on the wrap edge promotes the older pend data and parks the new one.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_shadowDigit3 <= '0;
      r_shadowDigit2 <= '0;
      r_shadowDigit1 <= '0;
      r_pendDigit3   <= '0;
      r_pendDigit2   <= '0;
      r_pendDigit1   <= '0;
      r_pending      <= 1'b0;
      r_frame        <= 1'b0;
    end else begin
      r_frame <= w_wrap;
      if (r_state == IDLE) begin
        if (load) begin
          r_shadowDigit3 <= digit3;
          r_shadowDigit2 <= digit2;
          r_shadowDigit1 <= digit1;
        end
      end else begin
        if (w_wrap && r_pending) begin
          r_shadowDigit3 <= r_pendDigit3;
          r_shadowDigit2 <= r_pendDigit2;
          r_shadowDigit1 <= r_pendDigit1;
        end
        if (load) begin
          r_pendDigit3 <= digit3;
          r_pendDigit2 <= digit2;
          r_pendDigit1 <= digit1;
          r_pending    <= 1'b1;
        end else if (w_wrap) begin
          r_pending <= 1'b0;
        end
      end
    end
  end

`ifdef LEAD_ZERO_BLANK_EN
  // Leading-zero suppression: tens only blanks when hundreds is also zero.
  always_comb begin
    w_blankHundreds = (r_shadowDigit3 == 4'd0);
    w_blankTens     = (r_shadowDigit3 == 4'd0) && (r_shadowDigit2 == 4'd0);
  end
`else
  // Every digit is always shown, leading zeros included.
  always_comb begin
    w_blankHundreds = 1'b0;
    w_blankTens     = 1'b0;
  end
`endif

  // Slot decode straight from the registered state and shadow digits; a
  // blanked slot keeps its timing but drives nothing onto the bus.
  always_comb begin
    w_slotDigit = 4'd0;
    w_slotBlank = 1'b1;
    w_anRaw     = 3'b000;
    case (r_state)
      D1: begin
        w_slotDigit = r_shadowDigit1;
        w_slotBlank = 1'b0;
        w_anRaw     = 3'b001;
      end
      D2: begin
        w_slotDigit = r_shadowDigit2;
        w_slotBlank = w_blankTens;
        w_anRaw     = w_blankTens ? 3'b000 : 3'b010;
      end
      D3: begin
        w_slotDigit = r_shadowDigit3;
        w_slotBlank = w_blankHundreds;
        w_anRaw     = w_blankHundreds ? 3'b000 : 3'b100;
      end
      default: begin
        w_slotDigit = 4'd0;
        w_slotBlank = 1'b1;
        w_anRaw     = 3'b000;
      end
    endcase
    w_segRaw = w_slotBlank ? 7'h00 : decodeBcd(w_slotDigit);
  end

  // Output polarity: a common-anode board wants both buses inverted.
  always_comb begin
    seg   = SEG_ACTIVE_LOW ? ~w_segRaw : w_segRaw;
    an    = SEG_ACTIVE_LOW ? ~w_anRaw  : w_anRaw;
    ready = ~r_pending;
    frame = r_frame;
  end

endmodule
